// File: rtl/spi_serf_pkg.sv
// Shared definitions for the SPI sensor-register slave: FSM states,
// register addresses, sample field offsets and the register read decode.
package spi_serf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_HI = 2'd2
  } state_t;

  localparam int SAMPLE_W = 96;

  // Frame geometry: bit 15 is R/W, bits 14:8 address, bits 7:0 data.
  localparam logic [4:0] CNT_ADDR_DONE = 5'd8;
  localparam logic [4:0] CNT_FRAME     = 5'd16;
  localparam logic [4:0] CNT_SAT       = 5'd17;

  localparam logic [6:0] ADDR_INT_CFG  = 7'h0D;
  localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
  localparam logic [6:0] ADDR_PITCH_L  = 7'h22;
  localparam logic [6:0] ADDR_PITCH_H  = 7'h23;
  localparam logic [6:0] ADDR_ROLL_L   = 7'h24;
  localparam logic [6:0] ADDR_ROLL_H   = 7'h25;
  localparam logic [6:0] ADDR_YAW_L    = 7'h26;
  localparam logic [6:0] ADDR_YAW_H    = 7'h27;
  localparam logic [6:0] ADDR_AX_L     = 7'h28;
  localparam logic [6:0] ADDR_AX_H     = 7'h29;
  localparam logic [6:0] ADDR_AY_L     = 7'h2A;
  localparam logic [6:0] ADDR_AY_H     = 7'h2B;
  localparam logic [6:0] ADDR_AZ_L     = 7'h2C;
  localparam logic [6:0] ADDR_AZ_H     = 7'h2D;

  // LSB position of each 16-bit field inside the 96-bit sample word.
  localparam int AX_LSB    = 80;
  localparam int AY_LSB    = 64;
  localparam int AZ_LSB    = 48;
  localparam int PITCH_LSB = 32;
  localparam int ROLL_LSB  = 16;
  localparam int YAW_LSB   = 0;

  // Byte returned for a read of addr; unmapped addresses read as zero.
  function automatic logic [7:0] reg_read(input logic [6:0]          addr,
                                          input logic [SAMPLE_W-1:0] shadow,
                                          input logic [7:0]          int_cfg,
                                          input logic [7:0]          who_am_i);
    logic [7:0] rd;
    rd = 8'h00;
    case (addr)
      ADDR_INT_CFG:  rd = int_cfg;
      ADDR_WHO_AM_I: rd = who_am_i;
      ADDR_PITCH_L:  rd = shadow[PITCH_LSB +: 8];
      ADDR_PITCH_H:  rd = shadow[PITCH_LSB + 8 +: 8];
      ADDR_ROLL_L:   rd = shadow[ROLL_LSB +: 8];
      ADDR_ROLL_H:   rd = shadow[ROLL_LSB + 8 +: 8];
      ADDR_YAW_L:    rd = shadow[YAW_LSB +: 8];
      ADDR_YAW_H:    rd = shadow[YAW_LSB + 8 +: 8];
      ADDR_AX_L:     rd = shadow[AX_LSB +: 8];
      ADDR_AX_H:     rd = shadow[AX_LSB + 8 +: 8];
      ADDR_AY_L:     rd = shadow[AY_LSB +: 8];
      ADDR_AY_H:     rd = shadow[AY_LSB + 8 +: 8];
      ADDR_AZ_L:     rd = shadow[AZ_LSB +: 8];
      ADDR_AZ_H:     rd = shadow[AZ_LSB + 8 +: 8];
      default:       rd = 8'h00;
    endcase
    return rd;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI inputs into the clk domain and produces
// one-clk edge strobes for SCLK and SS_n. The chains are deliberately not
// reset so that a bus held low across reset is never mistaken for a new
// SS_n falling edge once reset releases.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_sclk,
  input  logic i_ss_n,
  input  logic i_mosi,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_ss_n,
  output logic o_ss_rise,
  output logic o_ss_fall,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_ss_prev;
  logic                   w_sclk;
  logic                   w_ss_n;

  // Synchronizer chains plus one history flop per edge-detected signal.
  always_ff @(posedge clk) begin
    r_sclk_sync[0] <= i_sclk;
    r_ss_sync[0]   <= i_ss_n;
    r_mosi_sync[0] <= i_mosi;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      r_sclk_sync[k] <= r_sclk_sync[k-1];
      r_ss_sync[k]   <= r_ss_sync[k-1];
      r_mosi_sync[k] <= r_mosi_sync[k-1];
    end
    r_sclk_prev <= w_sclk;
    r_ss_prev   <= w_ss_n;
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_n      = r_ss_sync[SYNC_STAGES-1];
  assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign o_ss_n      = w_ss_n;
  assign o_sclk_rise = w_sclk & ~r_sclk_prev;
  assign o_sclk_fall = ~w_sclk & r_sclk_prev;
  assign o_ss_rise   = w_ss_n & ~r_ss_prev;
  assign o_ss_fall   = ~w_ss_n & r_ss_prev;

endmodule

// File: rtl/spi_serf.sv
// SPI slave exposing a small register map: a configuration register,
// an ID register and a shadow copy of the latest 96-bit motion sample.
// Shadow updates are held off while a frame is in flight so a multi-byte
// read never mixes two samples.
module spi_serf
  import spi_serf_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h6A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         SS_n,
  input  logic         SCLK,
  input  logic         MOSI,
  output logic         MISO,
  input  logic         sample_vld,
  input  logic [95:0]  sample_data,
  output logic         INT,
  output logic         setup,
  output logic         frame_done,
  output logic [1:0]   o_dbg_state
);

  logic          w_sclk_rise, w_sclk_fall, w_ss_n, w_ss_rise, w_ss_fall, w_mosi;
  state_t        r_state, w_state_next;
  logic [4:0]    r_cnt;
  logic [15:0]   r_rx;
  logic [7:0]    r_tx;
  logic          r_miso;
  logic [7:0]    r_int_cfg;
  logic [95:0]   r_shadow;
  logic [95:0]   r_pend_data;
  logic          r_pend;
  logic          r_int;
  logic          r_frame_done;
  logic [15:0]   w_rx_next;
  logic          w_frame_ok;
  logic          w_direct_load;
  logic          w_load;
  logic [95:0]   w_load_data;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .i_sclk      (SCLK),
    .i_ss_n      (SS_n),
    .i_mosi      (MOSI),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_ss_n      (w_ss_n),
    .o_ss_rise   (w_ss_rise),
    .o_ss_fall   (w_ss_fall),
    .o_mosi      (w_mosi)
  );

  assign w_rx_next     = {r_rx[14:0], w_mosi};
  assign w_frame_ok    = (r_state == SHIFT) && w_ss_rise && (r_cnt == CNT_FRAME);
  assign w_direct_load = sample_vld && w_ss_n;
  assign w_load        = w_direct_load || (r_pend && w_ss_rise);
  assign w_load_data   = w_direct_load ? sample_data : r_pend_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: a bus already low when we leave reset is ignored until it rises.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_state_next = SHIFT;
               else if (!w_ss_n) w_state_next = WAIT_HI;
      SHIFT:   if (w_ss_rise) w_state_next = IDLE;
      WAIT_HI: if (w_ss_n) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Serial datapath: shift in on SCLK rises, shift out on SCLK falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 5'd0;
      r_rx   <= 16'h0000;
      r_tx   <= 8'h00;
      r_miso <= 1'b0;
    end else if (r_state == IDLE && w_ss_fall) begin
      r_cnt  <= 5'd0;
      r_rx   <= 16'h0000;
      r_tx   <= 8'h00;
      r_miso <= 1'b0;
    end else if (r_state == SHIFT) begin
      if (w_sclk_rise) begin
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 5'd1;
        r_rx <= w_rx_next;
        // Eighth rise: header complete, fetch the read byte now.
        if (r_cnt == CNT_ADDR_DONE - 5'd1)
          r_tx <= w_rx_next[7] ? reg_read(w_rx_next[6:0], r_shadow, r_int_cfg, WHO_AM_I_VAL)
                               : 8'h00;
      end
      if (w_sclk_fall) begin
        if (r_cnt >= CNT_ADDR_DONE && r_cnt < CNT_FRAME) begin
          r_miso <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
        end else begin
          r_miso <= 1'b0;
        end
      end
    end
  end

  // Register commit, shadow loading with deferral, and interrupt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_cfg    <= 8'h00;
      r_shadow     <= '0;
      r_pend_data  <= '0;
      r_pend       <= 1'b0;
      r_int        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_ok;
      if (w_frame_ok && !r_rx[15] && r_rx[14:8] == ADDR_INT_CFG)
        r_int_cfg <= r_rx[7:0];
      if (sample_vld && !w_ss_n) begin
        r_pend      <= 1'b1;
        r_pend_data <= sample_data;
      end else if (w_load) begin
        r_pend <= 1'b0;
      end
      if (w_load) r_shadow <= w_load_data;
      // Set has priority over the read-of-last-byte clear.
      if (w_load && r_int_cfg[1])
        r_int <= 1'b1;
      else if (w_frame_ok && r_rx[15] && r_rx[14:8] == ADDR_AZ_H)
        r_int <= 1'b0;
    end
  end

  assign MISO        = SS_n ? 1'bz : r_miso;
  assign INT         = r_int;
  assign setup       = r_int_cfg[1];
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: doc/spi_serf.md
SPI_SERF -- requirements
Module: spi_serf

Interface
REQ-001 Parameter SYNC_STAGES, default 2, flops in the SCLK/SS_n/MOSI synchronizer chains.
REQ-002 Parameter WHO_AM_I_VAL, default 8'h6A, read-only value at address 0x0F.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  in  1  system clock; SCLK period >= 16 clk periods.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Ports SS_n, SCLK, MOSI  in  1 each  asynchronous SPI bus inputs; SCLK idles high.
REQ-007 Port MISO  out  1  serial read data; high-Z whenever raw SS_n is high.
REQ-008 Port sample_vld  in  1  one-clk pulse: sample_data is valid.
REQ-009 Port sample_data  in  96  {ax,ay,az,pitch,roll,yaw}, 16 bits each, ax in [95:80], yaw in [15:0].
REQ-010 Port INT  out  1  new-sample interrupt.
REQ-011 Port setup  out  1  mirror of INT_CFG[1].
REQ-012 Port frame_done  out  1  one-clk pulse after each valid 16-bit frame.

Function
REQ-013 Frame: 16 bits MSB first; bit15 = R/W (1 = read), bits14:8 = address, bits7:0 = write data (don't-care on reads).
REQ-014 MOSI SHALL be sampled on synchronized SCLK rising edges; MISO SHALL change only on synchronized SCLK falling edges.
REQ-015 FSM states: IDLE, SHIFT, WAIT_HI; IDLE->SHIFT on synchronized SS_n fall; SHIFT->IDLE on SS_n rise.
REQ-016 Bit counter SHALL count SCLK rises in SHIFT and saturate at 17.
REQ-017 On the 8th rise with bit15 = 1, the addressed byte SHALL be loaded into the MISO shift register; MISO carries that byte MSB first on falls 8..15.
REQ-018 MISO SHALL be 0 during bits 15..8 of every frame.
REQ-019 Register map: 0x0D INT_CFG RW; 0x0F WHO_AM_I RO.
REQ-020 Register map, read-only data: 0x22/0x23 pitch L/H; 0x24/0x25 roll; 0x26/0x27 yaw; 0x28/0x29 ax; 0x2A/0x2B ay; 0x2C/0x2D az.
REQ-021 Reads of unmapped addresses SHALL return 8'h00; writes to RO or unmapped addresses SHALL be ignored.
REQ-022 A write SHALL commit on SS_n rise only if the count is exactly 16; otherwise the frame is dropped with no commit and no frame_done.
REQ-023 On sample_vld with SS_n synchronized high, the shadow data registers SHALL load in the same clk.
REQ-024 On sample_vld with SS_n low, the load SHALL be deferred to the clk after SS_n rises; a newer pulse overwrites a pending one.
REQ-025 INT SHALL set on a shadow load when INT_CFG[1] = 1.
REQ-026 INT SHALL clear on frame_done of a read from 0x2D; if set and clear coincide, set wins.
REQ-027 frame_done SHALL pulse exactly 1 clk, at most 1 clk after the synchronized SS_n rise.

Reset
REQ-028 rst SHALL force: FSM to IDLE, counter 0, shift registers 0, INT_CFG 0, shadow registers 0, pending flag 0, INT 0, setup 0, frame_done 0.
REQ-029 If synchronized SS_n is low when rst deasserts, the FSM SHALL enter WAIT_HI and ignore the bus until SS_n rises; no partial frame is decoded.
REQ-030 rst asserted mid-frame SHALL abort the frame with no commit.

Structure
REQ-031 Package spi_serf_pkg SHALL hold register address constants, the FSM state enum and the sample field offsets.
REQ-032 Sub-module spi_sync_edge SHALL synchronize SCLK/SS_n/MOSI and emit one-clk rise/fall strobes; one instance is used.

Verification
REQ-033 Read 0x0F -> MISO byte 8'h6A; frame_done pulses once.
REQ-034 Write 0x0D = 8'h02 -> setup = 1. Then sample_vld with ax=16'h1234, yaw=16'hBEEF -> INT = 1. Reads of 0x28/0x29 return 8'h34/8'h12; reads of 0x26/0x27 return 8'hEF/8'hBE.
REQ-035 With INT = 1, read 0x2D -> INT clears after frame_done. Read 0x2C -> INT stays 1.
REQ-036 sample_vld pulsed mid-frame during a read of 0x22 -> old byte is returned; new data is readable in the next frame.
REQ-037 Frame of 12 SCLKs writing 0x0D -> INT_CFG stays unchanged and no frame_done. Read 0x50 -> 8'h00.
REQ-038 rst pulsed mid-frame with SS_n held low -> outputs at reset values; the next frame is decoded only after an SS_n high-then-low.
